// File: rtl/full_subtractor_cell.sv
// One-bit full-subtractor cell: d = a ^ b ^ bin, borrow out when a < b + bin.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor.sv
// Ripple-borrow subtractor computing a - b - bin, with an optional
// one-cycle output register stage and valid tracking.
module full_subtractor #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid
);

  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff_d;
  logic             bout_d;

  assign borrow[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (borrow[i]),
      .diff (diff_d[i]),
      .bout (borrow[i+1])
    );
  end

  assign bout_d = borrow[WIDTH];

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             vld_q;

    // Result register: loads only on valid operands, holds otherwise.
    always_ff @(posedge clk) begin
      if (rst) begin
        diff_q <= '0;
        bout_q <= 1'b0;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= in_valid;
        if (in_valid) begin
          diff_q <= diff_d;
          bout_q <= bout_d;
        end
      end
    end

    assign diff      = diff_q;
    assign bout      = bout_q;
    assign out_valid = vld_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};

    assign diff      = diff_d;
    assign bout      = bout_d;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_full_subtractor.sv
// Randomized and directed bench for full_subtractor across widths and output modes.
module tb_full_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // WIDTH=1 registered
  logic       v1 = 0, a1 = 0, b1 = 0, c1 = 0;
  logic       d1, o1, ov1;
  // WIDTH=8 registered
  logic       v8 = 0, c8 = 0;
  logic [7:0] a8 = 0, b8 = 0, d8;
  logic       o8, ov8;
  // WIDTH=8 combinational
  logic       vc = 0, cc = 0;
  logic [7:0] ac = 0, bc = 0, dc;
  logic       oc, ovc;
  // WIDTH=4 registered
  logic       v4 = 0, c4 = 0;
  logic [3:0] a4 = 0, b4 = 0, d4;
  logic       o4, ov4;

  full_subtractor #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .bin(c1),
    .diff(d1), .bout(o1), .out_valid(ov1));
  full_subtractor #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .bin(c8),
    .diff(d8), .bout(o8), .out_valid(ov8));
  full_subtractor #(.WIDTH(8), .REG_OUT(1'b0)) u_c8 (
    .clk(clk), .rst(rst), .in_valid(vc), .a(ac), .b(bc), .bin(cc),
    .diff(dc), .bout(oc), .out_valid(ovc));
  full_subtractor #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .bin(c4),
    .diff(d4), .bout(o4), .out_valid(ov4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {bout, diff} from plain integer arithmetic.
  function automatic int unsigned ref_sub(input int w, input int unsigned a, input int unsigned b,
                                          input int unsigned bin);
    int unsigned mask, d, bo;
    mask = (32'd1 << w) - 1;
    d    = (a - b - bin) & mask;
    bo   = (a < b + bin) ? 1 : 0;
    return (bo << w) | d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tt_exp [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

  initial begin
    logic [2:0] idx;
    logic [7:0] va [4] = '{8'h05, 8'h03, 8'h00, 8'hFF};
    logic [7:0] vb [4] = '{8'h03, 8'h05, 8'h00, 8'hFF};
    logic       vi [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [8:0] ve [4] = '{9'h002, 9'h1FE, 9'h1FF, 9'h1FF};
    int unsigned held4;

    // Reset state
    rst = 1; v1 = 1; v8 = 1; v4 = 1;
    tick(); tick();
    check("rst_w1", {d1, o1, ov1}, 3'b000);
    check("rst_w8", {d8, o8, ov8}, 10'd0);
    check("rst_w4", {d4, o4, ov4}, 6'd0);
    rst = 0; v8 = 0; v4 = 0;

    // WIDTH=1 truth table, one vector per cycle
    for (int i = 0; i < 8; i++) begin
      idx = i[2:0];
      {a1, b1, c1} = idx;
      v1 = 1;
      tick();
      check($sformatf("tt%0d", i), {d1, o1}, tt_exp[i]);
      check($sformatf("tt%0d_vld", i), ov1, 1'b1);
      check($sformatf("tt%0d_ref", i), {o1, d1}, ref_sub(1, a1, b1, c1));
    end

    // Hold with in_valid low
    {a1, b1, c1} = 3'b010; v1 = 1;
    tick();
    check("hold_load", {d1, o1, ov1}, 3'b111);
    v1 = 0;
    for (int i = 0; i < 3; i++) begin
      {a1, b1, c1} = 3'(i + 4);
      tick();
      check($sformatf("hold%0d", i), {d1, o1, ov1}, 3'b110);
    end

    // Reset mid-stream discards result and overrides in_valid
    {a1, b1, c1} = 3'b010; v1 = 1;
    tick();
    check("pre_rst", {d1, o1, ov1}, 3'b111);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("in_rst%0d", i), {d1, o1, ov1}, 3'b000);
    end
    rst = 0;
    {a1, b1, c1} = 3'b100; v1 = 1;
    tick();
    check("post_rst", {d1, o1, ov1}, 3'b101);
    v1 = 0;

    // WIDTH=8 directed, including wrap-around boundaries
    for (int i = 0; i < 4; i++) begin
      a8 = va[i]; b8 = vb[i]; c8 = vi[i]; v8 = 1;
      tick();
      check($sformatf("w8_dir%0d", i), {o8, d8}, ve[i]);
      check($sformatf("w8_dir%0d_ref", i), {o8, d8}, ref_sub(8, va[i], vb[i], vi[i]));
      check($sformatf("w8_dir%0d_vld", i), ov8, 1'b1);
    end
    v8 = 0;

    // WIDTH=8 combinational, zero latency, rst toggled to show no effect
    for (int i = 0; i < 24; i++) begin
      ac = 8'($urandom); bc = 8'($urandom); cc = 1'($urandom); vc = 1'($urandom);
      rst = 1'($urandom);
      #1;
      check($sformatf("comb%0d", i), {oc, dc}, ref_sub(8, ac, bc, cc));
      check($sformatf("comb%0d_vld", i), ovc, vc);
      #2;
    end
    rst = 0;
    tick();

    // WIDTH=4 back-to-back streaming
    for (int i = 0; i < 16; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom); v4 = 1;
      held4 = ref_sub(4, a4, b4, c4);
      tick();
      check($sformatf("strm%0d", i), {o4, d4}, held4);
      check($sformatf("strm%0d_vld", i), ov4, 1'b1);
    end

    // WIDTH=4 with random valid gaps
    for (int i = 0; i < 24; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom); v4 = 1'($urandom);
      if (v4) held4 = ref_sub(4, a4, b4, c4);
      tick();
      check($sformatf("gap%0d", i), {o4, d4}, held4);
      check($sformatf("gap%0d_vld", i), ov4, v4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/full_subtractor.md
Name: full_subtractor

Overview:
- Registered full subtractor: computes diff = a - b - bin, with a borrow-out.
- Default configuration is the classic 1-bit full-subtractor cell with registered outputs.
- WIDTH widens it into a ripple-borrow subtractor.
- Used as an arithmetic primitive in the datapath, and standalone as a truth-table demonstrator.

Parameters:
- WIDTH, 1, operand width in bits; must be >= 1.
- REG_OUT, 1, 1 = outputs registered on clk (1-cycle latency); 0 = purely combinational, and clk, rst and in_valid are ignored for data.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid this cycle; result is captured only when high (REG_OUT=1)
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in (subtracted at bit 0)
- diff  output  WIDTH  difference bits
- bout  output  1  borrow-out from the MSB
- out_valid  output  1  diff/bout hold a freshly captured result

Behaviour:
- Per-bit cell i, with borrow b_0 = bin:
  - d_i = a_i ^ b_i ^ b_i_in
  - borrow_i+1 = (~a_i & b_i) | (~(a_i ^ b_i) & b_i_in)
- bout = borrow out of bit WIDTH-1.
- Arithmetic identity: {bout, diff} as a signed (WIDTH+1)-bit value equals a - b - bin. Equivalently, diff = (a - b - bin) mod 2^WIDTH, and bout = 1 iff a < b + bin (unsigned compare).
- REG_OUT=1:
  - On a rising clk with rst=1: diff=0, bout=0, out_valid=0. Reset overrides in_valid.
  - With rst=0 and in_valid=1: diff/bout load the combinational result of the current a, b, bin; out_valid=1.
  - With rst=0 and in_valid=0: diff/bout hold their previous value; out_valid=0.
  - Latency is exactly 1 cycle. A new operand set may be accepted every cycle; there is no backpressure.
  - Reset asserted mid-stream discards the in-flight result. The first valid input after rst deasserts produces out_valid on the following edge.
- REG_OUT=0:
  - diff/bout follow the inputs combinationally, with no clock dependency.
  - out_valid = in_valid combinationally.
  - rst has no effect.
- Boundary conditions:
  - All-ones minus all-ones with bin=1 gives diff = all-ones, bout=1.
  - Zero minus zero with bin=1 gives diff = all-ones, bout=1 (wrap-around).
- No X propagation when in_valid=0 in registered mode: outputs hold.

Decomposition:
- No shared package is needed; WIDTH and REG_OUT are local parameters.
- One sub-module is natural: full_subtractor_cell, a combinational 1-bit cell (a, b, bin -> diff, bout).
  - Instantiated WIDTH times via generate, chaining borrow.
  - Top level adds the output register stage and valid tracking.

Test Plan:
- WIDTH=1, REG_OUT=1: apply all 8 (a,b,bin) combinations with in_valid=1, one per cycle. Required (diff,bout) one cycle later, in order for inputs 000..111: (0,0), (1,1), (1,1), (0,1), (1,0), (0,0), (0,0), (1,1); out_valid=1 each cycle.
- Reset: load a=0, b=1, bin=0 (result 1,1), then assert rst for one edge. Required: diff=0, bout=0, out_valid=0 after that edge, and it stays so while rst is high even with in_valid=1.
- Hold: after a result (1,1), drive in_valid=0 with changing operands for 3 cycles. Required: diff/bout stay (1,1); out_valid=0.
- WIDTH=8: 0x05-0x03, bin=0 -> diff=0x02, bout=0; 0x03-0x05, bin=0 -> diff=0xFE, bout=1; 0x00-0x00, bin=1 -> diff=0xFF, bout=1; 0xFF-0xFF, bin=1 -> diff=0xFF, bout=1.
- WIDTH=8, REG_OUT=0: random operands each step, checked same time-step against the reference model a - b - bin. Required: zero-latency match; out_valid mirrors in_valid.
- Back-to-back streaming, WIDTH=4, REG_OUT=1: 16 random valid inputs on consecutive cycles. Each output equals the model of the input one cycle earlier; no drops.
